// File: rtl/pattern_note_sequencer_pkg.sv
// Shared definitions for the pattern note sequencer: FSM state encoding and
// pattern-entry field layout ({rest, note, len} packed MSB to LSB).
package pattern_note_sequencer_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PLAYING = 1'b1
    } seq_state_t;

    localparam int LEN_LSB = 0;

    function automatic int note_lsb(input int len_w);
        return LEN_LSB + len_w;
    endfunction

    function automatic int rest_bit(input int note_w, input int len_w);
        return note_lsb(len_w) + note_w;
    endfunction

    function automatic int entry_w(input int note_w, input int len_w);
        return rest_bit(note_w, len_w) + 1;
    endfunction

endpackage

// File: rtl/rom_async.sv
// Asynchronous-read ROM whose contents come from a packed constant,
// word i occupying bits [i*DW +: DW].
module rom_async #(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter logic [DW*(2**AW)-1:0] INIT = '0
) (
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] o_data
);

    assign o_data = INIT[DW*int'(i_addr) +: DW];

endmodule

// File: rtl/pattern_note_sequencer.sv
// Pattern-driven note sequencer: steps a pattern ROM, looks up the note's
// phase delta and plays a per-entry volume envelope, with run/stop and loop window.
module pattern_note_sequencer
    import pattern_note_sequencer_pkg::*;
#(
    parameter int NOTE_W   = 2,
    parameter int LEN_W    = 5,
    parameter int PAT_AW   = 5,
    parameter int ENV_AW   = 4,
    parameter int ENV_LAST = 9,
    parameter int ENV_W    = 9,
    parameter logic [(2**PAT_AW)*(1+NOTE_W+LEN_W)-1:0] PATTERN_INIT = '0,
    parameter logic [(2**NOTE_W)*32-1:0]               PHASE_INIT   = '0,
    parameter logic [(2**ENV_AW)*ENV_W-1:0]            ENV_INIT     = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tick_stb,
    input  logic              i_note_stb,
    input  logic              i_enable,
    input  logic [PAT_AW-1:0] i_loop_start,
    input  logic [PAT_AW-1:0] i_loop_end,
    output logic [31:0]       o_phase_delta,
    output logic [ENV_W-1:0]  o_envelope,
    output logic              o_new_note,
    output logic [PAT_AW-1:0] o_position,
    output logic              o_playing
);

    localparam int EW       = entry_w(NOTE_W, LEN_W);
    localparam int REST_BIT = rest_bit(NOTE_W, LEN_W);
    localparam int NOTE_LSB = note_lsb(LEN_W);
    localparam logic [ENV_AW-1:0] ENV_SAT = ENV_AW'(ENV_LAST);

    seq_state_t        r_state;
    logic [PAT_AW-1:0] r_idx;
    logic [LEN_W-1:0]  r_dur;
    logic [ENV_AW-1:0] r_env_idx;
    logic              r_new_note;
    logic              r_playing;

    logic [EW-1:0]     w_entry;
    logic              w_rest;
    logic [NOTE_W-1:0] w_note;
    logic [LEN_W-1:0]  w_len;
    logic [ENV_W-1:0]  w_env_val;
    logic [PAT_AW-1:0] w_next_idx;
    logic              w_entry_end;

    rom_async #(.AW(PAT_AW), .DW(EW), .INIT(PATTERN_INIT)) u_pattern_rom (
        .i_addr (r_idx),
        .o_data (w_entry)
    );

    rom_async #(.AW(NOTE_W), .DW(32), .INIT(PHASE_INIT)) u_phase_rom (
        .i_addr (w_note),
        .o_data (o_phase_delta)
    );

    rom_async #(.AW(ENV_AW), .DW(ENV_W), .INIT(ENV_INIT)) u_env_rom (
        .i_addr (r_env_idx),
        .o_data (w_env_val)
    );

    assign w_rest = w_entry[REST_BIT];
    assign w_note = w_entry[NOTE_LSB +: NOTE_W];
    assign w_len  = w_entry[LEN_LSB +: LEN_W];

    // Loop wrap also fires at the last ROM slot so an inverted window still wraps.
    assign w_next_idx  = (r_idx == i_loop_end || r_idx == {PAT_AW{1'b1}}) ?
                         i_loop_start : r_idx + PAT_AW'(1);
    assign w_entry_end = i_note_stb && (r_dur == w_len);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_dur      <= '0;
            r_env_idx  <= '0;
            r_new_note <= 1'b0;
            r_playing  <= 1'b0;
        end else begin
            r_new_note <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_idx     <= '0;
                    r_dur     <= '0;
                    r_env_idx <= '0;
                    if (i_enable) begin
                        r_state    <= ST_PLAYING;
                        r_playing  <= 1'b1;
                        r_new_note <= 1'b1;
                    end
                end
                ST_PLAYING: begin
                    if (!i_enable) begin
                        r_state   <= ST_IDLE;
                        r_playing <= 1'b0;
                        r_idx     <= '0;
                        r_dur     <= '0;
                        r_env_idx <= '0;
                    end else if (w_entry_end) begin
                        // Entry start clears the envelope even if a tick coincides.
                        r_dur      <= '0;
                        r_idx      <= w_next_idx;
                        r_new_note <= 1'b1;
                        r_env_idx  <= '0;
                    end else begin
                        if (i_note_stb)
                            r_dur <= r_dur + LEN_W'(1);
                        if (i_tick_stb && r_env_idx != ENV_SAT)
                            r_env_idx <= r_env_idx + ENV_AW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_envelope = (r_playing && !w_rest) ? w_env_val : '0;
    assign o_new_note = r_new_note;
    assign o_position = r_idx;
    assign o_playing  = r_playing;

endmodule

// File: tb/tb_pattern_note_sequencer.sv
// Directed bench for pattern_note_sequencer with a built-in pattern, phase
// table and envelope; expected values are hand-derived from those tables.
module tb_pattern_note_sequencer;

    // Pattern: 0:{0,n1,len2} 1..7:{0,i%4,len0} 8:{rest,n3,len2} 9:{0,n0,len31} 31:{0,n3,len1}
    function automatic logic [255:0] mk_pat();
        logic [255:0] r;
        r = '0;
        r[0 +: 8] = 8'h22;
        for (int i = 1; i < 8; i++) r[i*8 +: 8] = 8'((i % 4) << 5);
        r[8*8 +: 8]  = 8'hE2;
        r[9*8 +: 8]  = 8'h1F;
        r[31*8 +: 8] = 8'h61;
        return r;
    endfunction

    // phase[n] = 0x11111111 * (n+1)
    function automatic logic [127:0] mk_phase();
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 4; n++) r[n*32 +: 32] = 32'(32'h1111_1111 * (n + 1));
        return r;
    endfunction

    // env[i] = 20*i + 3
    function automatic logic [143:0] mk_env();
        logic [143:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*9 +: 9] = 9'(20 * i + 3);
        return r;
    endfunction

    localparam logic [255:0] PAT_INIT = mk_pat();
    localparam logic [127:0] PH_INIT  = mk_phase();
    localparam logic [143:0] EN_INIT  = mk_env();

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_tick_stb = 1'b0;
    logic        i_note_stb = 1'b0;
    logic        i_enable = 1'b0;
    logic [4:0]  i_loop_start = 5'd0;
    logic [4:0]  i_loop_end = 5'd31;
    logic [31:0] o_phase_delta;
    logic [8:0]  o_envelope;
    logic        o_new_note;
    logic [4:0]  o_position;
    logic        o_playing;

    int n_checks = 0;
    int n_fail = 0;

    pattern_note_sequencer #(
        .NOTE_W(2), .LEN_W(5), .PAT_AW(5), .ENV_AW(4), .ENV_LAST(9), .ENV_W(9),
        .PATTERN_INIT(PAT_INIT), .PHASE_INIT(PH_INIT), .ENV_INIT(EN_INIT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick_stb(i_tick_stb), .i_note_stb(i_note_stb),
        .i_enable(i_enable), .i_loop_start(i_loop_start), .i_loop_end(i_loop_end),
        .o_phase_delta(o_phase_delta), .o_envelope(o_envelope), .o_new_note(o_new_note),
        .o_position(o_position), .o_playing(o_playing)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic strobe();
        i_note_stb = 1'b1;
        step();
        i_note_stb = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pos [9] = '{2, 3, 4, 5, 6, 4, 5, 6, 4};

        step(); step();
        chk("rst_playing", 32'(o_playing), 32'd0);
        chk("rst_position", 32'(o_position), 32'd0);
        chk("rst_envelope", 32'(o_envelope), 32'd0);
        chk("rst_new_note", 32'(o_new_note), 32'd0);
        chk("rst_phase", o_phase_delta, 32'h2222_2222);

        i_rst = 1'b0;
        strobe();
        chk("idle_strobe_ignored", 32'(o_position), 32'd0);

        // Start playing: entry 0 = note1, len2
        i_enable = 1'b1;
        step();
        chk("start_new_note", 32'(o_new_note), 32'd1);
        chk("start_playing", 32'(o_playing), 32'd1);
        chk("start_env", 32'(o_envelope), 32'd3);
        i_tick_stb = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("start_pulse_once", 32'(o_new_note), 32'd0);
        chk("env_after5", 32'(o_envelope), 32'd103);
        for (int k = 0; k < 7; k++) step();
        chk("env_saturated", 32'(o_envelope), 32'd183);
        i_tick_stb = 1'b0;

        strobe();
        chk("len2_strobe1", 32'(o_position), 32'd0);
        strobe();
        chk("len2_strobe2", 32'(o_position), 32'd0);
        i_tick_stb = 1'b1;
        strobe();
        i_tick_stb = 1'b0;
        chk("len2_strobe3", 32'(o_position), 32'd1);
        chk("advance_new_note", 32'(o_new_note), 32'd1);
        chk("tick_vs_start_env", 32'(o_envelope), 32'd3);
        chk("phase_entry1", o_phase_delta, 32'h2222_2222);
        step();
        chk("advance_pulse_end", 32'(o_new_note), 32'd0);

        // Loop window 4..6 with zero-length entries
        i_loop_start = 5'd4;
        i_loop_end = 5'd6;
        for (int k = 0; k < 9; k++) begin
            strobe();
            chk($sformatf("loop_pos%0d", k), 32'(o_position), 32'(exp_pos[k]));
        end

        // Stop at index 5, then restart
        strobe();
        chk("stop_at5", 32'(o_position), 32'd5);
        i_enable = 1'b0;
        step();
        chk("stopped_playing", 32'(o_playing), 32'd0);
        chk("stopped_env", 32'(o_envelope), 32'd0);
        strobe();
        chk("stopped_position", 32'(o_position), 32'd0);
        i_enable = 1'b1;
        step();
        chk("restart_position", 32'(o_position), 32'd0);
        chk("restart_new_note", 32'(o_new_note), 32'd1);

        // Walk to rest entry 8
        i_loop_start = 5'd0;
        i_loop_end = 5'd31;
        for (int k = 0; k < 10; k++) strobe();
        chk("rest_position", 32'(o_position), 32'd8);
        chk("rest_env0", 32'(o_envelope), 32'd0);
        chk("rest_phase", o_phase_delta, 32'h4444_4444);
        i_tick_stb = 1'b1;
        strobe();
        i_tick_stb = 1'b0;
        chk("rest_env1", 32'(o_envelope), 32'd0);
        strobe();
        chk("rest_env2", 32'(o_envelope), 32'd0);
        chk("rest_hold", 32'(o_position), 32'd8);
        strobe();
        chk("after_rest_pos", 32'(o_position), 32'd9);
        chk("after_rest_env", 32'(o_envelope), 32'd3);
        chk("after_rest_phase", o_phase_delta, 32'h1111_1111);

        // Maximum length entry lasts 32 strobes
        for (int k = 0; k < 31; k++) strobe();
        chk("maxlen_hold", 32'(o_position), 32'd9);
        strobe();
        chk("maxlen_advance", 32'(o_position), 32'd10);

        // Inverted window: run to end of ROM, wrap to start
        i_loop_start = 5'd3;
        i_loop_end = 5'd1;
        for (int k = 0; k < 21; k++) strobe();
        chk("inv_reach_end", 32'(o_position), 32'd31);
        strobe();
        chk("inv_end_hold", 32'(o_position), 32'd31);
        strobe();
        chk("inv_wrap", 32'(o_position), 32'd3);
        chk("inv_wrap_new_note", 32'(o_new_note), 32'd1);

        // Reset mid-play coincident with a note strobe
        i_rst = 1'b1;
        i_note_stb = 1'b1;
        step();
        i_note_stb = 1'b0;
        i_enable = 1'b0;
        chk("midrst_position", 32'(o_position), 32'd0);
        chk("midrst_playing", 32'(o_playing), 32'd0);
        chk("midrst_new_note", 32'(o_new_note), 32'd0);
        chk("midrst_env", 32'(o_envelope), 32'd0);
        chk("midrst_phase", o_phase_delta, 32'h2222_2222);
        i_rst = 1'b0;
        step();
        chk("post_rst_new_note", 32'(o_new_note), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_note_sequencer.md
Name: pattern_note_sequencer

Overview:
Parametrised note sequencer for any APU channel (pulse, triangle or noise). It steps through a pattern ROM whose entries carry rest/note/length fields and looks up the phase delta for the current note in a phase table ROM. It also plays a per-channel volume envelope from an envelope ROM. Run/stop control and a runtime loop window are added, so one block replaces the hard-coded per-channel sequencers and feeds the channel oscillator and mixer directly.

Parameters:
NOTE_W, 2, note field width; phase table depth = 2**NOTE_W
LEN_W, 5, length field width; an entry lasts len+1 note strobes
PAT_AW, 5, pattern address width; pattern depth = 2**PAT_AW
ENV_AW, 4, envelope address width
ENV_LAST, 9, last envelope index; the envelope saturates here
ENV_W, 9, envelope output width
PATTERN_FILE, "", hex init for pattern ROM; entry = {rest[1], note[NOTE_W], len[LEN_W]}
PHASE_TABLE_FILE, "", hex init for the 32-bit phase delta ROM
ENV_FILE, "", hex init for the ENV_W-bit envelope ROM

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_tick_stb  in  1  envelope step strobe, one cycle
i_note_stb  in  1  pattern step strobe, one cycle
i_enable  in  1  level; 1 = play, 0 = stop
i_loop_start  in  PAT_AW  index to jump to at loop wrap
i_loop_end  in  PAT_AW  last index before wrap
o_phase_delta  out  32  phase delta for the current note
o_envelope  out  ENV_W  current volume; 0 when stopped or resting
o_new_note  out  1  one-cycle pulse when an entry starts
o_position  out  PAT_AW  current pattern index
o_playing  out  1  high in PLAYING

Behaviour:
- Reset: state IDLE; index, duration count and envelope index all 0. Outputs: o_envelope=0, o_new_note=0, o_position=0, o_playing=0. o_phase_delta = phase table entry for the note of pattern[0].
- FSM IDLE -> PLAYING when i_enable=1. On the transition clock edge: index<=0, dur<=0, env_idx<=0. o_new_note is registered and is 1 in the first PLAYING cycle.
- FSM PLAYING -> IDLE when i_enable=0. Index, duration count and envelope index are cleared on the same edge.
- PLAYING, on i_note_stb:
  - If dur==len of the current entry: dur<=0; index advances; o_new_note pulses the next cycle.
  - Otherwise: dur<=dur+1.
- Index advance rule: if index==i_loop_end or index==2**PAT_AW-1, then index<=i_loop_start; otherwise index<=index+1.
  - If i_loop_start>i_loop_end, playback runs to the end of the ROM and wraps to i_loop_start.
  - Loop inputs are sampled only at the advance instant.
- Envelope index: cleared on an entry start. Otherwise it increments on i_tick_stb and saturates at ENV_LAST.
  - If an entry start and i_tick_stb coincide, the clear wins.
  - In IDLE the envelope index is held at 0.
- o_envelope = 0 in IDLE or when the current entry's rest bit is 1; otherwise env_rom[env_idx].
- o_phase_delta is an asynchronous ROM lookup of the current entry's note. It has zero cycles of latency from an index change and is valid in all states.
- o_position and o_playing are direct register outputs.
- Counter widths: dur is LEN_W bits. len=2**LEN_W-1 is legal and lasts 2**LEN_W strobes.
- i_note_stb and i_tick_stb are ignored in IDLE.
- Reset mid-play: returns to the reset state on the next edge; no o_new_note pulse.

Decomposition:
- Shared include note_seq_defs.vh: field offset/width macros for pattern entries (REST_BIT, NOTE_LSB, LEN_LSB) and the FSM state encodings.
- Reuse the existing rom_async three times: pattern, phase table, envelope. No new sub-module.

Test Plan:
- Reset, then i_enable=1. Pattern[0]={0,note1,len 2}. -> o_new_note pulses once; o_position stays 0 for 3 note strobes, then becomes 1; o_phase_delta = phase[1].
- Loop window start=4, end=6, all lengths 0. -> o_position sequence 0,1,2,3,4,5,6,4,5,6,4.
- Rest entry (rest=1). -> o_envelope=0 for its full duration while o_phase_delta still tracks its note.
- 12 tick strobes within one entry, ENV_LAST=9. -> env index goes 0..9 and holds; o_envelope=env_rom[9]. Then a tick coincident with an entry start -> env index reads 0.
- i_enable dropped mid-pattern at index 5, then raised. -> o_playing=0 and o_envelope=0 while low; on restart o_position=0 with an o_new_note pulse.
- i_rst asserted mid-play with i_note_stb high the same cycle. -> all outputs return to reset values; no advance, no o_new_note.
